led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_ctrl_pkg.sv | 34 +++
 rtl/led_mode_ctrl_if.sv | 40 ++++
 rtl/button_debounce.sv | 62 ++++++
 rtl/led_mode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_led_mode_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_ctrl_pkg
// Shared definitions for the LED mode controller:
//   mode_e        - operating mode seen on the mode output (OFF/ON/SLOW/FAST)
//   press_state_e - press-classification FSM state
//   cnt_width()   - width of a counter that runs 0..n-1 (at least 1 bit)
//   next_mode()   - short-press mode sequence with wrap-around
// -----------------------------------------------------------------------------
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_e;

  // A counter holding 0..n-1 needs $clog2(n) bits; never return zero width.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF; the 2-bit add wraps.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl_if
// Groups the button input and the LED/mode/event outputs of led_mode_ctrl.
//   button    - raw push-button level, asynchronous, 1 = pressed
//   led       - LED drive, 1 = on
//   mode      - current mode (mode_e)
//   short_evt - one-cycle pulse on a recognised short press
//   long_evt  - one-cycle pulse on a recognised long press
// Handshake: there is no valid/ready pair. short_evt and long_evt are
// single-cycle strobes with no back-pressure; a consumer must sample them in
// the cycle they are high. mode and led are levels, valid every cycle.
// modports: master = the side that drives the button and observes outputs,
//           slave  = the controller.
// -----------------------------------------------------------------------------
interface led_mode_ctrl_if;
  import led_ctrl_pkg::*;

  logic  button;
  logic  led;
  mode_e mode;
  logic  short_evt;
  logic  long_evt;

  modport master (
    output button,
    input  led,
    input  mode,
    input  short_evt,
    input  long_evt
  );

  modport slave (
    input  button,
    output led,
    output mode,
    output short_evt,
    output long_evt
  );

endinterface

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
//   clk    - clock
//   reset  - asynchronous active-low reset
//   button - raw asynchronous button level
//   deb    - debounced level; follows the synchronised level once it has
//            differed for DEBOUNCE_CYCLES consecutive cycles
// -----------------------------------------------------------------------------
module button_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic deb
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle where the synchronised level agrees with deb restarts the
  // count, so only an unbroken run of DEBOUNCE_CYCLES disagreements flips deb.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
// Single-button LED controller. A short press steps the mode
// OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF; a long press forces OFF.
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous active-low reset
//   bus       - led_mode_ctrl_if.slave: button in; led, mode, short_evt,
//               long_evt out
//   state_dbg - current press-classification FSM state
// Parameters: DEBOUNCE_CYCLES, LONG_PRESS_CYCLES (>= 2), SLOW_HALF, FAST_HALF
// (LED half-periods in cycles for the two blink modes).
// -----------------------------------------------------------------------------
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 20,
  parameter int SLOW_HALF         = 8,
  parameter int FAST_HALF         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  led_mode_ctrl_if.slave        bus,
  output press_state_e          state_dbg
);

  localparam int HW        = cnt_width(LONG_PRESS_CYCLES);
  localparam int BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int BW        = cnt_width(BLINK_MAX);

  // The long press fires on the edge where the hold counter steps onto
  // LONG_PRESS_CYCLES-1, i.e. while it still reads LONG_PRESS_CYCLES-2.
  // Together with the one cycle spent leaving IDLE this puts long_evt
  // LONG_PRESS_CYCLES cycles after deb rises.
  localparam logic [HW-1:0] HOLD_PRE_LAST = HW'(LONG_PRESS_CYCLES - 2);
  localparam logic [BW-1:0] SLOW_LAST     = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST     = BW'(FAST_HALF - 1);

  logic          deb;

  press_state_e  state_q;
  logic [HW-1:0] hold_q;
  logic          short_q;
  logic          long_q;
  mode_e         mode_q;

  logic          short_c;
  logic          long_c;

  logic [BW-1:0] blink_cnt_q;
  logic [BW-1:0] blink_cnt_d;
  logic          phase_q;
  logic          phase_d;
  logic [BW-1:0] half_last;
  logic          blink_mode;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .button (bus.button),
    .deb    (deb)
  );

  // Press classification. Both events are decided only in PRESSED, so they
  // are mutually exclusive, and leaving PRESSED on the same edge keeps each
  // one exactly one cycle wide.
  always_comb begin
    short_c = 1'b0;
    long_c  = 1'b0;
    if (state_q == ST_PRESSED) begin
      if (!deb) begin
        short_c = 1'b1;
      end else if (hold_q == HOLD_PRE_LAST) begin
        long_c = 1'b1;
      end
    end
  end

  // Press FSM with registered event and mode outputs. IDLE is only ever
  // entered with deb low (reset, or a falling edge seen in PRESSED or
  // LONG_HELD), so deb high while IDLE is always a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      mode_q  <= MODE_OFF;
    end else begin
      short_q <= short_c;
      long_q  <= long_c;

      case (state_q)
        ST_IDLE: begin
          if (deb) begin
            state_q <= ST_PRESSED;
            hold_q  <= '0;
          end
        end
        ST_PRESSED: begin
          if (short_c) begin
            state_q <= ST_IDLE;
          end else if (long_c) begin
            state_q <= ST_LONG_HELD;
            hold_q  <= hold_q + 1'b1;
          end else begin
            hold_q  <= hold_q + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!deb) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (short_c) begin
        mode_q <= next_mode(mode_q);
      end else if (long_c) begin
        mode_q <= MODE_OFF;
      end
    end
  end

  // Blink generator. Every event changes the mode, so restarting on an event
  // lines the first blink phase (LED on) up with the new mode's first cycle.
  assign blink_mode = (mode_q == MODE_BLINK_SLOW) || (mode_q == MODE_BLINK_FAST);
  assign half_last  = (mode_q == MODE_BLINK_SLOW) ? SLOW_LAST : FAST_LAST;

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b1;
    if (!(short_c || long_c) && blink_mode) begin
      if (blink_cnt_q == half_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // led is decoded from registered mode and phase so it switches in the same
  // cycle as mode and never sees the button directly.
  assign bus.led       = (mode_q == MODE_ON) || (blink_mode && phase_q);
  assign bus.mode      = mode_q;
  assign bus.short_evt = short_q;
  assign bus.long_evt  = long_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
// Table of press/gap scenarios with expected event counts and final mode,
// hand-written reset-during-press sequence, then randomized button activity.
// Every cycle the DUT outputs are compared against a behavioural model built
// from the controller's rules (debounce run length, press duration, mode
// sequence, blink period arithmetic); events go through an expected queue.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;
  import led_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int SLOW = 8;
  localparam int FAST = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  press_state_e state_dbg;

  always #5 clk = ~clk;

  led_mode_ctrl_if bus ();

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .SLOW_HALF         (SLOW),
    .FAST_HALF         (FAST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int ev_short = 0;
  int ev_long  = 0;

  // Scoreboard: {long, mode after event} for every event the model predicts.
  logic [2:0] exp_q[$];

  // ---------------- reference model ----------------
  int   n;           // edge counter
  logic mq[$];       // button samples from the last two edges (synchroniser)
  logic m_deb;
  int   m_run;       // consecutive edges the synchronised level disagreed
  logic m_armed;     // a press is being timed
  int   m_rise;      // edge at which deb rose
  int   m_short_at;  // edge at which a pending short event appears
  int   m_mode;
  int   m_chg;       // edge of the last mode change
  logic m_short;
  logic m_long;

  function automatic void model_reset();
    mq.delete();
    mq.push_back(1'b0);
    mq.push_back(1'b0);
    m_deb      = 1'b0;
    m_run      = 0;
    m_armed    = 1'b0;
    m_rise     = 0;
    m_short_at = -1;
    m_mode     = 0;
    m_chg      = n;
    m_short    = 1'b0;
    m_long     = 1'b0;
  endfunction

  // Advance the model across one rising edge, b = button level at that edge.
  // Press rules: deb high for LONG or more cycles -> long event LONG cycles
  // after the rise; shorter -> short event one cycle after deb falls.
  function automatic void model_edge(input logic b);
    logic seen;
    n++;
    if (!reset) begin
      model_reset();
      return;
    end
    m_short = (m_short_at == n);
    m_long  = m_armed && (n == m_rise + LONG);
    if (m_long) m_armed = 1'b0;

    seen = mq.pop_front();
    mq.push_back(b);
    if (seen != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = seen;
        m_run = 0;
        if (m_deb) begin
          m_armed = 1'b1;
          m_rise  = n;
        end else if (m_armed) begin
          m_short_at = n + 1;
          m_armed    = 1'b0;
        end
      end
    end else begin
      m_run = 0;
    end

    if (m_short) begin
      m_mode = (m_mode + 1) % 4;
      m_chg  = n;
      exp_q.push_back(3'(m_mode));
    end else if (m_long) begin
      m_mode = 0;
      m_chg  = n;
      exp_q.push_back(3'b100);
    end
  endfunction

  function automatic int m_led();
    case (m_mode)
      0:       return 0;
      1:       return 1;
      2:       return ((((n - m_chg) / SLOW) % 2) == 0) ? 1 : 0;
      default: return ((((n - m_chg) / FAST) % 2) == 0) ? 1 : 0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, want, n);
    end
  endtask

  task automatic compare_cycle();
    logic [2:0] e;
    check("mode", bus.mode, m_mode);
    check("led", bus.led, m_led());
    check("short_evt", bus.short_evt, m_short);
    check("long_evt", bus.long_evt, m_long);
    if (bus.short_evt) ev_short++;
    if (bus.long_evt)  ev_long++;
    if (bus.short_evt || bus.long_evt) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL event_sb: event long=%0d mode=%0d seen, none expected (edge %0d)",
                 bus.long_evt, bus.mode, n);
      end else begin
        e = exp_q.pop_front();
        check("event_sb", {bus.long_evt, bus.mode}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge(bus.button);
    #1;
    compare_cycle();
  endtask

  task automatic assert_reset_now();
    reset = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("rst_mode", bus.mode, 0);
    check("rst_led", bus.led, 0);
    check("rst_short", bus.short_evt, 0);
    check("rst_long", bus.long_evt, 0);
    check("rst_state", state_dbg, ST_IDLE);
  endtask

  task automatic press(input int hold, input int gap);
    bus.button = 1'b1;
    repeat (hold) step();
    bus.button = 1'b0;
    repeat (gap) step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int hold;
    int gap;
    int exp_short;
    int exp_long;
    int exp_mode;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{10, 20, 1, 0, 1};  // OFF -> ON
    vecs[1]  = '{10, 30, 1, 0, 2};  // ON -> BLINK_SLOW
    vecs[2]  = '{10, 30, 1, 0, 3};  // -> BLINK_FAST
    vecs[3]  = '{10, 20, 1, 0, 0};  // wrap to OFF
    vecs[4]  = '{10, 20, 1, 0, 1};
    vecs[5]  = '{10, 40, 1, 0, 2};
    vecs[6]  = '{40, 30, 0, 1, 0};  // long from BLINK_SLOW, no short on release
    vecs[7]  = '{1, 15, 0, 0, 0};   // glitches
    vecs[8]  = '{2, 15, 0, 0, 0};
    vecs[9]  = '{3, 15, 0, 0, 0};
    vecs[10] = '{19, 20, 1, 0, 1};  // one cycle short of long
    vecs[11] = '{20, 20, 0, 1, 0};  // exactly long
    vecs[12] = '{4, 20, 1, 0, 1};   // shortest accepted press
    vecs[13] = '{10, 20, 1, 0, 2};
    vecs[14] = '{10, 30, 1, 0, 3};
    vecs[15] = '{25, 20, 0, 1, 0};  // long from BLINK_FAST
    vecs[16] = '{30, 20, 0, 1, 0};  // long from OFF stays OFF

    n = 0;
    bus.button = 1'b0;
    model_reset();
    assert_reset_now();
    repeat (3) step();
    reset = 1'b1;

    // Idle after reset: nothing happens.
    ev_short = 0;
    ev_long  = 0;
    repeat (50) step();
    check("idle_short", ev_short, 0);
    check("idle_long", ev_long, 0);
    check("idle_mode", bus.mode, 0);

    for (int i = 0; i < 17; i++) begin
      ev_short = 0;
      ev_long  = 0;
      press(vecs[i].hold, vecs[i].gap);
      check($sformatf("row%0d_short", i), ev_short, vecs[i].exp_short);
      check($sformatf("row%0d_long", i), ev_long, vecs[i].exp_long);
      check($sformatf("row%0d_mode", i), bus.mode, vecs[i].exp_mode);
    end

    // Reset five cycles into a hold, released with the button still down.
    bus.button = 1'b1;
    repeat (5) step();
    assert_reset_now();
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rel_still_idle", state_dbg, ST_IDLE);
    end
    step();
    check("rel_pressed", state_dbg, ST_PRESSED);
    ev_short = 0;
    ev_long  = 0;
    press(5, 20);
    check("rel_short", ev_short, 1);
    check("rel_long", ev_long, 0);
    check("rel_mode", bus.mode, 1);

    // Randomized activity: clean presses, chatter and occasional resets.
    for (int r = 0; r < 150; r++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        bus.button = 1'($urandom_range(0, 1));
        assert_reset_now();
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b1;
      end else if (kind <= 2) begin
        repeat ($urandom_range(5, 30)) begin
          bus.button = 1'($urandom_range(0, 1));
          step();
        end
      end else begin
        press($urandom_range(1, 45), $urandom_range(1, 30));
      end
    end
    bus.button = 1'b0;
    repeat (30) step();

    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
